// File: rtl/scorehand_pkg.sv
// Shared constants, rank type and mod-10 reduction for the Baccarat hand scorer.
// Optional natural-hand flag is enabled with SCOREHAND_NATURAL_EN (see scorehand_unit).
package scorehand_pkg;

  localparam int unsigned CARD_W    = 4;
  localparam int unsigned SCORE_MOD = 10;
  localparam int unsigned SUM_W     = 5;

  typedef logic [CARD_W-1:0] rank_t;

  localparam rank_t RANK_NONE  = 4'd0;
  localparam rank_t RANK_ACE   = 4'd1;
  localparam rank_t RANK_TEN   = 4'd10;
  localparam rank_t RANK_JACK  = 4'd11;
  localparam rank_t RANK_QUEEN = 4'd12;
  localparam rank_t RANK_KING  = 4'd13;

  // Raw sums reach 27, so both the 20 and the 10 reduction steps are needed.
  function automatic logic [CARD_W-1:0] mod_score(input logic [SUM_W-1:0] sum);
    logic [SUM_W-1:0] red;
    if (sum >= SUM_W'(2 * SCORE_MOD)) begin
      red = sum - SUM_W'(2 * SCORE_MOD);
    end else if (sum >= SUM_W'(SCORE_MOD)) begin
      red = sum - SUM_W'(SCORE_MOD);
    end else begin
      red = sum;
    end
    return CARD_W'(red);
  endfunction

endpackage

// File: rtl/scorehand_card_value.sv
// Maps one card rank to its Baccarat point value (0-9); tens, faces, empty and illegal ranks score 0.
module card_value
  import scorehand_pkg::*;
(
  input  rank_t              rank_i,
  output logic [CARD_W-1:0]  value_c
);

  always_comb begin
    value_c = '0;
    if ((rank_i >= RANK_ACE) && (rank_i < RANK_TEN)) begin
      value_c = rank_i;
    end
  end

endmodule

// File: rtl/scorehand_unit.sv
// Baccarat hand scorer: combinational mod-10 score plus a registered copy for the display path.
// Define SCOREHAND_NATURAL_EN to add the registered natural_q (two-card 8/9) flag.
module scorehand_unit
  import scorehand_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CARD_W-1:0] card1,
  input  logic [CARD_W-1:0] card2,
  input  logic [CARD_W-1:0] card3,
  output logic [CARD_W-1:0] total,
`ifdef SCOREHAND_NATURAL_EN
  output logic              natural_q,
`endif
  output logic [CARD_W-1:0] total_q
);

  logic [CARD_W-1:0] value1_c;
  logic [CARD_W-1:0] value2_c;
  logic [CARD_W-1:0] value3_c;
  logic [SUM_W-1:0]  sum_c;
  logic [CARD_W-1:0] total_d;

  card_value u_value1 (.rank_i(card1), .value_c(value1_c));
  card_value u_value2 (.rank_i(card2), .value_c(value2_c));
  card_value u_value3 (.rank_i(card3), .value_c(value3_c));

  always_comb begin
    sum_c   = SUM_W'(value1_c) + SUM_W'(value2_c) + SUM_W'(value3_c);
    total   = mod_score(sum_c);
    total_d = total;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

`ifdef SCOREHAND_NATURAL_EN
  logic [SUM_W-1:0]  pair_sum_c;
  logic [CARD_W-1:0] pair_score_c;
  logic              natural_d;

  // A natural is judged on the first two cards only; a zero-value third card does not suppress it.
  always_comb begin
    pair_sum_c   = SUM_W'(value1_c) + SUM_W'(value2_c);
    pair_score_c = mod_score(pair_sum_c);
    natural_d    = (value3_c == '0) && (pair_score_c >= CARD_W'(8));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      natural_q <= 1'b0;
    end else begin
      natural_q <= natural_d;
    end
  end
`endif

endmodule

// File: tb/tb_scorehand_unit.sv
// Directed self-checking bench for scorehand_unit: score table, reset/latency, exhaustive sweep.
module tb_scorehand_unit;

  logic       clk;
  logic       rst;
  logic [3:0] card1;
  logic [3:0] card2;
  logic [3:0] card3;
  logic [3:0] total;
  logic [3:0] total_q;
`ifdef SCOREHAND_NATURAL_EN
  logic       natural_q;
`endif

  int checks;
  int errors;

  scorehand_unit dut (
    .clk     (clk),
    .rst     (rst),
    .card1   (card1),
    .card2   (card2),
    .card3   (card3),
    .total   (total),
`ifdef SCOREHAND_NATURAL_EN
    .natural_q(natural_q),
`endif
    .total_q (total_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_value(input int r);
    case (r)
      1, 2, 3, 4, 5, 6, 7, 8, 9: return r;
      default:                   return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_score(input int a, input int b, input int c);
    return 4'((ref_value(a) + ref_value(b) + ref_value(c)) % 10);
  endfunction

  task automatic set_cards(input int a, input int b, input int c);
    card1 = 4'(a);
    card2 = 4'(b);
    card3 = 4'(c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cards(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (total_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_total_q got %0d want 0", total_q);
    end
`ifdef SCOREHAND_NATURAL_EN
    checks++;
    if (natural_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_natural_q got %0b want 0", natural_q);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Hand-computed vectors: {card1, card2, card3, expected total}
  task automatic test_scores();
    int vec [16][4] = '{
      '{3, 5, 0, 8},  '{3, 9, 0, 2},   '{11, 5, 0, 5},  '{2, 4, 3, 9},
      '{3, 12, 2, 5}, '{3, 8, 4, 5},   '{13, 7, 10, 7}, '{13, 11, 12, 0},
      '{7, 8, 9, 4},  '{4, 8, 7, 9},   '{5, 9, 6, 0},   '{6, 8, 7, 1},
      '{0, 0, 0, 0},  '{14, 15, 9, 9}, '{1, 10, 0, 1},  '{9, 9, 9, 7}
    };
    for (int i = 0; i < 16; i++) begin
      set_cards(vec[i][0], vec[i][1], vec[i][2]);
      #1;
      checks++;
      if (total !== 4'(vec[i][3])) begin
        errors++;
        $display("FAIL score_vec%0d cards %0d,%0d,%0d got %0d want %0d",
                 i, vec[i][0], vec[i][1], vec[i][2], total, vec[i][3]);
      end
    end
  endtask

  task automatic test_reset_latency();
    @(negedge clk);
    set_cards(7, 8, 9);
    @(posedge clk);
    #1;
    checks++;
    if (total_q !== 4'd4) begin
      errors++;
      $display("FAIL latency_load got %0d want 4", total_q);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (total_q !== 4'd0) begin
      errors++;
      $display("FAIL async_clear got %0d want 0", total_q);
    end
    checks++;
    if (total !== 4'd4) begin
      errors++;
      $display("FAIL total_in_reset got %0d want 4", total);
    end
    @(posedge clk);
    #1;
    checks++;
    if (total_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold got %0d want 0", total_q);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (total_q !== 4'd0) begin
      errors++;
      $display("FAIL release_no_edge got %0d want 0", total_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (total_q !== 4'd4) begin
      errors++;
      $display("FAIL release_first_edge got %0d want 4", total_q);
    end
  endtask

  // Cards change every cycle; total_q must trail total by exactly one edge.
  task automatic test_back_to_back();
    int seq [5][4] = '{
      '{3, 5, 0, 8}, '{6, 8, 7, 1}, '{13, 11, 12, 0}, '{4, 8, 7, 9}, '{2, 4, 3, 9}
    };
    logic [3:0] prev;
    prev = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_cards(seq[i][0], seq[i][1], seq[i][2]);
      #1;
      checks++;
      if (total_q !== prev) begin
        errors++;
        $display("FAIL b2b_before_edge%0d got %0d want %0d", i, total_q, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (total_q !== 4'(seq[i][3])) begin
        errors++;
        $display("FAIL b2b_after_edge%0d got %0d want %0d", i, total_q, seq[i][3]);
      end
      prev = 4'(seq[i][3]);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 16; c++) begin
          set_cards(a, b, c);
          #1;
          exp = ref_score(a, b, c);
          checks++;
          if ((total !== exp) || (total > 4'd9)) begin
            errors++;
            $display("FAIL sweep cards %0d,%0d,%0d got %0d want %0d", a, b, c, total, exp);
          end
        end
      end
    end
  endtask

`ifdef SCOREHAND_NATURAL_EN
  task automatic test_natural();
    int vec [5][4] = '{
      '{4, 5, 0, 1}, '{4, 5, 13, 1}, '{4, 5, 2, 0}, '{10, 8, 0, 1}, '{3, 4, 0, 0}
    };
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_cards(vec[i][0], vec[i][1], vec[i][2]);
      @(posedge clk);
      #1;
      checks++;
      if (natural_q !== 1'(vec[i][3])) begin
        errors++;
        $display("FAIL natural_vec%0d got %0b want %0d", i, natural_q, vec[i][3]);
      end
    end
    @(negedge clk);
    set_cards(4, 5, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (natural_q !== 1'b0) begin
      errors++;
      $display("FAIL natural_async_clear got %0b want 0", natural_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_cards(0, 0, 0);
    test_reset();
    test_scores();
    test_reset_latency();
    test_back_to_back();
    test_sweep();
`ifdef SCOREHAND_NATURAL_EN
    test_natural();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
